// File: rtl/ico_spi_ctrl_master_if.sv
// spi_ctrl endpoint bus: the front end (master) strobes the OR-combined endpoint array (slave).
interface ico_spi_ctrl_master_if #(
  parameter int NUM_EP = 4
);
  logic              spi_ctrl_hd;
  logic              spi_ctrl_so;
  logic              spi_ctrl_si;
  logic [7:0]        spi_ctrl_di;
  logic [7:0]        spi_ctrl_do;
  logic [NUM_EP-1:0] spi_ctrl_epsel;

  modport master (
    output spi_ctrl_hd,
    output spi_ctrl_so,
    output spi_ctrl_si,
    output spi_ctrl_di,
    output spi_ctrl_epsel,
    input  spi_ctrl_do
  );

  modport slave (
    input  spi_ctrl_hd,
    input  spi_ctrl_so,
    input  spi_ctrl_si,
    input  spi_ctrl_di,
    input  spi_ctrl_epsel,
    output spi_ctrl_do
  );
endinterface

// File: rtl/ico_spi_ctrl_master.sv
// SPI-slave front end (mode 0, MSB first) turning host SPI traffic into spi_ctrl endpoint strobes.
// Byte 0 of a transaction selects the endpoint; later bytes are full-duplex data.
module ico_spi_ctrl_master #(
  parameter int NUM_EP      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_ss_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  ico_spi_ctrl_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    HDR,
    PRE,
    DATA
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sck_s;
  logic ss_s;
  logic mosi_s;
  logic sck_prev;
  logic sck_rise;
  logic sck_fall;
  logic byte_done;

  logic [2:0]        bit_cnt;
  logic [7:0]        rx;
  logic [7:0]        rx_next;
  logic [7:0]        tx;
  logic [7:0]        di_q;
  logic [NUM_EP-1:0] epsel_q;
  logic [NUM_EP-1:0] addr_dec;
  logic              miso_q;
  logic              si_q;
  logic              hd;
  logic              so;

  // ss_n synchroniser resets to "deselected" so reset release never looks like a select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_s;
    end
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev;
  assign sck_fall  = ~sck_s & sck_prev;
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign rx_next   = {rx[6:0], mosi_s};

  // Out-of-range addresses decode to no endpoint, so spi_ctrl_do reads back as zero
  always_comb begin
    addr_dec = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      addr_dec[i] = ({24'd0, rx_next} == 32'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hd      = 1'b0;
    so      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ss_s) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ss_s) begin
          state_d = IDLE;
        end else if (byte_done) begin
          state_d = HDR;
        end
      end
      HDR: begin
        if (ss_s) begin
          state_d = IDLE;
        end else begin
          hd      = 1'b1;
          state_d = PRE;
        end
      end
      PRE: begin
        if (ss_s) begin
          state_d = IDLE;
        end else begin
          so      = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (ss_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Deselect wipes the byte in flight; di keeps the last completed byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      rx      <= 8'd0;
      tx      <= 8'd0;
      di_q    <= 8'd0;
      epsel_q <= '0;
      miso_q  <= 1'b0;
      si_q    <= 1'b0;
    end else begin
      si_q <= 1'b0;
      if (state_q == IDLE || ss_s) begin
        bit_cnt <= 3'd0;
        rx      <= 8'd0;
        tx      <= 8'd0;
        epsel_q <= '0;
        miso_q  <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx      <= rx_next;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (sck_fall && (state_q == ADDR || state_q == DATA)) begin
          miso_q <= tx[7];
          tx     <= {tx[6:0], 1'b0};
        end
        case (state_q)
          ADDR: begin
            if (byte_done) begin
              epsel_q <= addr_dec;
            end
          end
          PRE: begin
            tx <= bus.spi_ctrl_do;
          end
          DATA: begin
            if (byte_done) begin
              tx   <= bus.spi_ctrl_do;
              di_q <= rx_next;
              si_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso           = miso_q;
  assign bus.spi_ctrl_hd    = hd;
  assign bus.spi_ctrl_so    = so;
  assign bus.spi_ctrl_si    = si_q;
  assign bus.spi_ctrl_di    = di_q;
  assign bus.spi_ctrl_epsel = epsel_q;

endmodule
